// File: rtl/masked_table_rom.sv
// masked_table_rom: reloadable multi-channel lookup table for the masked S-box path.
// NCH independent copies of a DEPTH x DATA_W table, all written by one streaming
// load port and read by per-channel lookup pipelines of RD_LAT (1 or 2) cycles.
// Optional feature macro: TABLE_CSUM_EN adds the ld_csum port and an XOR
// checksum check on every completed load (ld_err reports a mismatch).
module masked_table_rom #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NCH    = 2,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NCH-1:0]           in_valid,
    input  logic [NCH*ADDR_W-1:0]    in_addr,
    output logic [NCH-1:0]           out_valid,
    output logic [NCH*DATA_W-1:0]    out_data,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     ld_ready,
    output logic                     ld_done,
    output logic                     tbl_ok,
`ifdef TABLE_CSUM_EN
    input  logic [DATA_W-1:0]        ld_csum,
`endif
    output logic                     ld_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ld_ready_q, ld_ready_d;
    logic               ld_done_q, ld_done_d;
    logic               tbl_ok_q, tbl_ok_d;
`ifdef TABLE_CSUM_EN
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  csum_q, csum_d;
    logic               ld_err_q, ld_err_d;
`endif

    // A load starts only from EMPTY or ACTIVE; ld_start during LOAD is ignored.
    logic start_c;
    // Word accepted from the load stream this cycle.
    logic wr_c;

    assign start_c = ld_start && (state_q != ST_LOAD);
    assign wr_c    = (state_q == ST_LOAD) && ld_valid && ld_ready_q;

    // Load controller state and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            cnt_q      <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
            tbl_ok_q   <= 1'b0;
`ifdef TABLE_CSUM_EN
            acc_q      <= '0;
            csum_q     <= '0;
            ld_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_ready_q <= ld_ready_d;
            ld_done_q  <= ld_done_d;
            tbl_ok_q   <= tbl_ok_d;
`ifdef TABLE_CSUM_EN
            acc_q      <= acc_d;
            csum_q     <= csum_d;
            ld_err_q   <= ld_err_d;
`endif
        end
    end

    // Next-state logic: the load ends on the cycle the counter has reached DEPTH,
    // which is one cycle after the last word was accepted.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_ready_d = ld_ready_q;
        ld_done_d  = 1'b0;
        tbl_ok_d   = tbl_ok_q;
`ifdef TABLE_CSUM_EN
        acc_d      = acc_q;
        csum_d     = csum_q;
        ld_err_d   = ld_err_q;
`endif
        unique case (state_q)
            ST_EMPTY, ST_ACTIVE: begin
                if (ld_start) begin
                    state_d    = ST_LOAD;
                    cnt_d      = '0;
                    ld_ready_d = 1'b1;
                    tbl_ok_d   = 1'b0;
`ifdef TABLE_CSUM_EN
                    acc_d      = '0;
                    csum_d     = ld_csum;
                    ld_err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (wr_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef TABLE_CSUM_EN
                    acc_d = acc_q ^ ld_data;
`endif
                    if (cnt_q == CNT_W'(DEPTH - 1)) begin
                        ld_ready_d = 1'b0;
                    end
                end
                if (cnt_q == CNT_W'(DEPTH)) begin
                    ld_ready_d = 1'b0;
                    ld_done_d  = 1'b1;
`ifdef TABLE_CSUM_EN
                    if (acc_q != csum_q) begin
                        state_d  = ST_EMPTY;
                        ld_err_d = 1'b1;
                    end else begin
                        state_d  = ST_ACTIVE;
                        tbl_ok_d = 1'b1;
                    end
`else
                    state_d  = ST_ACTIVE;
                    tbl_ok_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d    = ST_EMPTY;
                ld_ready_d = 1'b0;
                tbl_ok_d   = 1'b0;
            end
        endcase
    end

    assign ld_ready = ld_ready_q;
    assign ld_done  = ld_done_q;
    assign tbl_ok   = tbl_ok_q;
`ifdef TABLE_CSUM_EN
    assign ld_err   = ld_err_q;
`else
    assign ld_err   = 1'b0;
`endif

    // Per-channel table copy and lookup pipeline.
    for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [ADDR_W-1:0] addr_c;
        logic              accept_c;
        logic              v1_q;
        logic [DATA_W-1:0] d1_q;

        assign addr_c   = in_addr[g*ADDR_W +: ADDR_W];
        assign accept_c = in_valid[g] && tbl_ok_q && en && !ld_start;

        // Table copy write; contents survive reset and are only replaced by a load.
        always_ff @(posedge clk) begin
            if (wr_c) begin
                mem[cnt_q[ADDR_W-1:0]] <= ld_data;
            end
        end

        // First stage: registered-address read; a load start flushes the valid bit.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v1_q <= 1'b0;
                d1_q <= '0;
            end else begin
                if (start_c) begin
                    v1_q <= 1'b0;
                end else if (en) begin
                    v1_q <= accept_c;
                end
                if (en) begin
                    d1_q <= mem[addr_c];
                end
            end
        end

        if (RD_LAT == 2) begin : g_lat2
            logic              v2_q;
            logic [DATA_W-1:0] d2_q;

            // Optional output register stage, held with the first stage by en.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    if (start_c) begin
                        v2_q <= 1'b0;
                    end else if (en) begin
                        v2_q <= v1_q;
                    end
                    if (en) begin
                        d2_q <= d1_q;
                    end
                end
            end

            assign out_valid[g]                 = v2_q;
            assign out_data[g*DATA_W +: DATA_W] = d2_q;
        end else begin : g_lat1
            assign out_valid[g]                 = v1_q;
            assign out_data[g*DATA_W +: DATA_W] = d1_q;
        end
    end

endmodule

// File: tb/tb_masked_table_rom.sv
// tb_masked_table_rom: directed bench for masked_table_rom with RD_LAT=2 and RD_LAT=1
// instances sharing all inputs. Table word i is i[7:0] ^ 8'hA5.
module tb_masked_table_rom;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NCH    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  en;
    logic [NCH-1:0]        in_valid;
    logic [NCH*ADDR_W-1:0] in_addr;
    logic                  ld_start;
    logic                  ld_valid;
    logic [DATA_W-1:0]     ld_data;
`ifdef TABLE_CSUM_EN
    logic [DATA_W-1:0]     ld_csum;
`endif

    logic [NCH-1:0]        out_valid, out_valid1;
    logic [NCH*DATA_W-1:0] out_data, out_data1;
    logic                  ld_ready, ld_ready1;
    logic                  ld_done, ld_done1;
    logic                  tbl_ok, tbl_ok1;
    logic                  ld_err, ld_err1;

    masked_table_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCH(NCH), .RD_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_addr(in_addr),
        .out_valid(out_valid), .out_data(out_data),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .tbl_ok(tbl_ok),
`ifdef TABLE_CSUM_EN
        .ld_csum(ld_csum),
`endif
        .ld_err(ld_err)
    );

    masked_table_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCH(NCH), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_addr(in_addr),
        .out_valid(out_valid1), .out_data(out_data1),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready1), .ld_done(ld_done1), .tbl_ok(tbl_ok1),
`ifdef TABLE_CSUM_EN
        .ld_csum(ld_csum),
`endif
        .ld_err(ld_err1)
    );

    int checks   = 0;
    int failures = 0;
    int cyc;

    // en-hold sequence on channel 0 (RD_LAT=2 instance)
    int en_seq [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    int va_seq [9] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
    int ad_seq [9] = '{1, 2, 0, 0, 0, 3, 4, 0, 0};
    int ov_exp [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int od_exp [9] = '{0, 'hA4, 'hA4, 'hA4, 'hA4, 'hA7, 'hA6, 'hA1, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams the full table; optional extra ld_start at load cycle restart_at.
    // cycles = edges from the ld_start edge to the ld_done edge (-1 on timeout).
    task automatic run_load(input int restart_at, output int cycles);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'hA5;
        step();
        chk("start_ld_ready", 32'(ld_ready), 32'd1);
        chk("start_tbl_ok", 32'(tbl_ok), 32'd0);
        chk("start_flush_lat2", 32'(out_valid), 32'd0);
        chk("start_flush_lat1", 32'(out_valid1), 32'd0);
        in_valid = '0;
        ld_start = 1'b0;
        cycles   = -1;
        for (int k = 1; k <= 1100; k++) begin
            ld_data  = 8'(k - 1) ^ 8'hA5;
            ld_start = (k == restart_at);
            step();
            if (ld_done) begin
                cycles = k;
                break;
            end
        end
        ld_start = 1'b0;
        ld_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b1;
        in_valid = '0;
        in_addr  = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
`ifdef TABLE_CSUM_EN
        ld_csum  = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_ld_done", 32'(ld_done), 32'd0);
        chk("rst_tbl_ok", 32'(tbl_ok), 32'd0);
        chk("rst_ld_err", 32'(ld_err), 32'd0);
        rst = 1'b1;

        // Lookups with no table loaded are dropped.
        in_valid = 2'b11;
        in_addr  = {10'h123, 10'h045};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("noload_out_valid", 32'(out_valid), 32'd0);
            chk("noload_out_valid1", 32'(out_valid1), 32'd0);
            chk("noload_tbl_ok", 32'(tbl_ok), 32'd0);
            chk("noload_ld_ready", 32'(ld_ready), 32'd0);
        end

        // Full load with ld_valid held high.
        run_load(0, cyc);
        chk("load1_cycles", 32'(cyc), 32'd1025);
        chk("load1_tbl_ok", 32'(tbl_ok), 32'd1);
        chk("load1_ld_ready", 32'(ld_ready), 32'd0);
        chk("load1_ld_err", 32'(ld_err), 32'd0);

        // Boundary addresses: ch0 = last word, ch1 = first word.
        in_valid = 2'b11;
        in_addr  = {10'h000, 10'h3FF};
        step();
        in_valid = 2'b00;
        chk("ld_done_pulse", 32'(ld_done), 32'd0);
        chk("lat1_valid", 32'(out_valid1), 32'h3);
        chk("lat1_data", 32'(out_data1), 32'hA55A);
        chk("lat2_valid_early", 32'(out_valid), 32'h0);
        step();
        chk("lat2_valid", 32'(out_valid), 32'h3);
        chk("lat2_data", 32'(out_data), 32'hA55A);
        chk("lat1_valid_once", 32'(out_valid1), 32'h0);

        // Back-to-back ch0 lookups with en low for three cycles.
        for (int i = 0; i < 9; i++) begin
            en       = en_seq[i][0];
            in_valid = {1'b0, va_seq[i][0]};
            in_addr  = {10'h000, 10'(ad_seq[i])};
            step();
            chk("en_hold_valid", 32'(out_valid), 32'(ov_exp[i]));
            if (ov_exp[i] != 0) begin
                chk("en_hold_data", 32'(out_data[7:0]), 32'(od_exp[i]));
            end
        end
        en       = 1'b1;
        in_valid = 2'b00;

        // Reload while lookups are in flight; a second ld_start mid-load is ignored.
        in_valid = 2'b11;
        in_addr  = {10'h010, 10'h020};
        step();
        run_load(10, cyc);
        chk("load2_cycles", 32'(cyc), 32'd1025);
        chk("load2_tbl_ok", 32'(tbl_ok), 32'd1);

        in_valid = 2'b11;
        in_addr  = {10'h2AA, 10'h155};
        step();
        in_valid = 2'b00;
        chk("reload_lat1_valid", 32'(out_valid1), 32'h3);
        chk("reload_lat1_data", 32'(out_data1), 32'h0FF0);
        step();
        chk("reload_lat2_valid", 32'(out_valid), 32'h3);
        chk("reload_lat2_data", 32'(out_data), 32'h0FF0);

`ifdef TABLE_CSUM_EN
        // Correct checksum: XOR of the whole table is 8'h00.
        ld_csum = 8'h00;
        run_load(0, cyc);
        chk("csum_ok_cycles", 32'(cyc), 32'd1025);
        chk("csum_ok_err", 32'(ld_err), 32'd0);
        chk("csum_ok_tbl_ok", 32'(tbl_ok), 32'd1);

        // Wrong checksum: error, table not usable, lookups dropped.
        ld_csum = 8'h01;
        run_load(0, cyc);
        chk("csum_bad_cycles", 32'(cyc), 32'd1025);
        chk("csum_bad_err", 32'(ld_err), 32'd1);
        chk("csum_bad_tbl_ok", 32'(tbl_ok), 32'd0);
        in_valid = 2'b11;
        in_addr  = {10'h001, 10'h002};
        step();
        step();
        in_valid = 2'b00;
        chk("csum_bad_drop", 32'(out_valid), 32'h0);
        chk("csum_bad_drop1", 32'(out_valid1), 32'h0);
        chk("csum_bad_err_sticky", 32'(ld_err), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
